// File: rtl/cache_pkg.sv
// cache_pkg: command/state encodings and address field helpers for the cache tag controller
package cache_pkg;
  typedef enum logic [3:0] {RD = 4'd0, WR = 4'd1, IRD = 4'd2, INV = 4'd3, CLR = 4'd8, PRN = 4'd9} cmd_e;
  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, CLEAR} state_e;
  function automatic logic [63:0] addr_tag(input logic [63:0] a, input int off_w, input int idx_w);
    return a >> (off_w + idx_w);
  endfunction
  function automatic logic [63:0] addr_index(input logic [63:0] a, input int off_w, input int idx_w);
    return (a >> off_w) & ((64'd1 << idx_w) - 64'd1);
  endfunction
  function automatic logic [63:0] addr_offset(input logic [63:0] a, input int off_w);
    return a & ((64'd1 << off_w) - 64'd1);
  endfunction
endpackage

// File: rtl/cache_tag_ctrl_plru_tree.sv
// plru_tree: tree pseudo-LRU victim select and touch update (ports: tree_i bits, touch_i way, victim_o way, tree_o updated bits)
module plru_tree #(
  parameter int WAYS = 8
) (
  input  logic [WAYS-2:0]         tree_i,
  input  logic [$clog2(WAYS)-1:0] touch_i,
  output logic [$clog2(WAYS)-1:0] victim_o,
  output logic [WAYS-2:0]         tree_o
);
  localparam int LVL = $clog2(WAYS);
  logic [LVL-1:0] vn, un;
  always_comb begin
    vn = '0;
    victim_o = '0;
    for (int l = 0; l < LVL; l++) begin
      victim_o[LVL-1-l] = tree_i[vn];
      vn = (vn << 1) + LVL'(1) + LVL'(tree_i[vn]);
    end
  end
  always_comb begin
    un = '0;
    tree_o = tree_i;
    for (int l = 0; l < LVL; l++) begin
      tree_o[un] = ~touch_i[LVL-1-l];
      un = (un << 1) + LVL'(1) + LVL'(touch_i[LVL-1-l]);
    end
  end
endmodule

// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: set-associative tag/valid/dirty/PLRU controller (in: clk, rstb, valid, n, address; out: ready, done, hit, hit_way, evict*, counters)
module cache_tag_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int SETS       = 256,
  parameter int WAYS       = 8,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    valid,
  input  logic [3:0]              n,
  input  logic [ADDR_W-1:0]       address,
  output logic                    ready,
  output logic                    done,
  output logic                    hit,
  output logic [$clog2(WAYS)-1:0] hit_way,
  output logic                    evict,
  output logic [ADDR_W-1:0]       evict_addr,
  output logic                    evict_dirty,
  output logic [CNT_W-1:0]        hit_cntr,
  output logic [CNT_W-1:0]        miss_cntr,
  output logic [CNT_W-1:0]        rd_cntr,
  output logic [CNT_W-1:0]        wr_cntr
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  state_e state_q;
  logic [3:0] cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0] clr_q;
  logic [TAG_W-1:0] tag_q [SETS][WAYS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [WAYS-2:0] plru_q [SETS];
  logic ready_q, done_q, hit_q, evict_q, evict_dirty_q;
  logic [WAY_W-1:0] hit_way_q;
  logic [ADDR_W-1:0] evict_addr_q;
  logic [CNT_W-1:0] hit_cntr_q, miss_cntr_q, rd_cntr_q, wr_cntr_q;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tg;
  logic hit_any, inv_any, is_acc, is_wr;
  logic [WAY_W-1:0] hit_w, inv_w, plru_vic, way;
  logic [WAYS-2:0] plru_nxt;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input logic en);
    return c + CNT_W'(en && !(&c));
  endfunction
  assign idx = IDX_W'(addr_index(64'(addr_q), OFF_W, IDX_W));
  assign tg = TAG_W'(addr_tag(64'(addr_q), OFF_W, IDX_W));
  assign is_wr = cmd_q == WR;
  assign is_acc = cmd_q == RD || cmd_q == WR || cmd_q == IRD;
  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_w = '0;
    inv_any = 1'b0;
    inv_w = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tg) begin
        hit_any = 1'b1;
        hit_w = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_any = 1'b1;
        inv_w = WAY_W'(w);
      end
    end
  end
  assign way = hit_any ? hit_w : inv_any ? inv_w : plru_vic;
  plru_tree #(.WAYS(WAYS)) u_plru (
    .tree_i  (plru_q[idx]),
    .touch_i (way),
    .victim_o(plru_vic),
    .tree_o  (plru_nxt)
  );
  // Tag storage carries no reset; a tag is only meaningful under its valid bit.
  always_ff @(posedge clk)
    if (!rstb && state_q == LOOKUP && is_acc && !hit_any) tag_q[idx][way] <= tg;
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q <= IDLE;
      cmd_q <= '0;
      addr_q <= '0;
      clr_q <= '0;
      ready_q <= 1'b1;
      done_q <= 1'b0;
      hit_q <= 1'b0;
      hit_way_q <= '0;
      evict_q <= 1'b0;
      evict_addr_q <= '0;
      evict_dirty_q <= 1'b0;
      hit_cntr_q <= '0;
      miss_cntr_q <= '0;
      rd_cntr_q <= '0;
      wr_cntr_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: if (valid && ready_q) begin
          cmd_q <= n;
          addr_q <= address;
          clr_q <= '0;
          ready_q <= 1'b0;
          state_q <= n == CLR ? CLEAR : LOOKUP;
        end
        // All set, PLRU and counter state commits here so done and counters appear together.
        LOOKUP: begin
          state_q <= UPDATE;
          done_q <= 1'b1;
          hit_q <= is_acc && hit_any;
          hit_way_q <= way;
          evict_q <= 1'b0;
          evict_dirty_q <= 1'b0;
          evict_addr_q <= {tag_q[idx][way], idx, {OFF_W{1'b0}}};
          if (is_acc) begin
            if (!hit_any) begin
              valid_q[idx][way] <= 1'b1;
              evict_q <= valid_q[idx][way];
              evict_dirty_q <= valid_q[idx][way] && dirty_q[idx][way];
            end
            dirty_q[idx][way] <= is_wr || (hit_any && dirty_q[idx][way]);
            plru_q[idx] <= plru_nxt;
            hit_cntr_q <= sat(hit_cntr_q, hit_any);
            miss_cntr_q <= sat(miss_cntr_q, !hit_any);
            rd_cntr_q <= sat(rd_cntr_q, !is_wr);
            wr_cntr_q <= sat(wr_cntr_q, is_wr);
          end else if (cmd_q == INV && hit_any) begin
            valid_q[idx][hit_w] <= 1'b0;
            dirty_q[idx][hit_w] <= 1'b0;
            evict_q <= 1'b1;
            evict_dirty_q <= dirty_q[idx][hit_w];
          end
        end
        UPDATE: begin
          state_q <= IDLE;
          done_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          valid_q[clr_q] <= '0;
          dirty_q[clr_q] <= '0;
          plru_q[clr_q] <= '0;
          hit_cntr_q <= '0;
          miss_cntr_q <= '0;
          rd_cntr_q <= '0;
          wr_cntr_q <= '0;
          clr_q <= clr_q + IDX_W'(1);
          // done registers one cycle early so it lines up with the last set's sweep.
          done_q <= clr_q == IDX_W'(SETS - 2);
          if (clr_q == IDX_W'(SETS - 1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
      endcase
    end
  end
  assign ready = ready_q;
  assign done = done_q;
  assign hit = hit_q;
  assign hit_way = hit_way_q;
  assign evict = evict_q;
  assign evict_addr = evict_addr_q;
  assign evict_dirty = evict_dirty_q;
  assign hit_cntr = hit_cntr_q;
  assign miss_cntr = miss_cntr_q;
  assign rd_cntr = rd_cntr_q;
  assign wr_cntr = wr_cntr_q;
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb_cache_tag_ctrl: directed scoreboard bench for cache_tag_ctrl (16-bit and 4-bit counter instances)
module tb_cache_tag_ctrl;
  import cache_pkg::*;
  logic clk = 1'b0;
  logic rstb, valid;
  logic [3:0] n;
  logic [31:0] address;
  logic ready, done, hit, evict, evict_dirty;
  logic [2:0] hit_way;
  logic [31:0] evict_addr;
  logic [15:0] hit_cntr, miss_cntr, rd_cntr, wr_cntr;
  logic ready4, done4, hit4, evict4, evict_dirty4;
  logic [2:0] hit_way4;
  logic [31:0] evict_addr4;
  logic [3:0] hit_cntr4, miss_cntr4, rd_cntr4, wr_cntr4;
  int checks = 0, errors = 0;
  int e_hit, e_miss, e_rd, e_wr;
  typedef struct {
    string tag;
    logic [3:0] cmd;
    int lat;
    int hit;
    int way;
    int ev;
    logic [31:0] eaddr;
    logic edirty;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  cache_tag_ctrl u_dut (
    .clk(clk), .rstb(rstb), .valid(valid), .n(n), .address(address),
    .ready(ready), .done(done), .hit(hit), .hit_way(hit_way), .evict(evict),
    .evict_addr(evict_addr), .evict_dirty(evict_dirty), .hit_cntr(hit_cntr),
    .miss_cntr(miss_cntr), .rd_cntr(rd_cntr), .wr_cntr(wr_cntr)
  );
  cache_tag_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rstb(rstb), .valid(valid), .n(n), .address(address),
    .ready(ready4), .done(done4), .hit(hit4), .hit_way(hit_way4), .evict(evict4),
    .evict_addr(evict_addr4), .evict_dirty(evict_dirty4), .hit_cntr(hit_cntr4),
    .miss_cntr(miss_cntr4), .rd_cntr(rd_cntr4), .wr_cntr(wr_cntr4)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] sat4(input int v);
    return v > 15 ? 32'd15 : 32'(v);
  endfunction
  task automatic chk_cnt(input string tag);
    chk({tag, ".hit_cntr"}, 32'(hit_cntr), 32'(e_hit));
    chk({tag, ".miss_cntr"}, 32'(miss_cntr), 32'(e_miss));
    chk({tag, ".rd_cntr"}, 32'(rd_cntr), 32'(e_rd));
    chk({tag, ".wr_cntr"}, 32'(wr_cntr), 32'(e_wr));
    chk({tag, ".miss_cntr4"}, 32'(miss_cntr4), sat4(e_miss));
    chk({tag, ".rd_cntr4"}, 32'(rd_cntr4), sat4(e_rd));
  endtask
  // ev: -1 unchecked, 0 no evict, 1 evict with address/dirty, 2 evict only
  task automatic issue(input string tag, input logic [3:0] c, input logic [31:0] a, input int lat,
                       input int h, input int w, input int ev, input logic [31:0] eaddr,
                       input logic edirty, input bit spam);
    exp_t e;
    int cyc;
    bit busy;
    sb.push_back('{tag, c, lat, h, w, ev, eaddr, edirty});
    @(negedge clk);
    cyc = 0;
    while (!ready && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".ready_in"}, 32'(ready), 32'd1);
    valid = 1'b1;
    n = c;
    address = a;
    @(posedge clk);
    @(negedge clk);
    valid = spam;
    n = WR;
    address = 32'h00ff_ff00;
    cyc = 1;
    busy = !ready;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      busy = busy && !ready;
    end
    valid = 1'b0;
    e = sb.pop_front();
    chk({e.tag, ".latency"}, 32'(cyc), 32'(e.lat));
    chk({e.tag, ".busy"}, 32'(busy), 32'd1);
    if (e.hit >= 0) chk({e.tag, ".hit"}, 32'(hit), 32'(e.hit));
    if (e.way >= 0) chk({e.tag, ".hit_way"}, 32'(hit_way), 32'(e.way));
    if (e.ev >= 0) chk({e.tag, ".evict"}, 32'(evict), 32'(e.ev != 0));
    if (e.ev == 1) begin
      chk({e.tag, ".evict_addr"}, evict_addr, e.eaddr);
      chk({e.tag, ".evict_dirty"}, 32'(evict_dirty), 32'(e.edirty));
    end
    if (e.cmd inside {RD, WR, IRD}) begin
      if (e.hit == 1) e_hit++; else e_miss++;
      if (e.cmd == WR) e_wr++; else e_rd++;
    end else if (e.cmd == CLR) begin
      e_hit = 0; e_miss = 0; e_rd = 0; e_wr = 0;
    end
    chk_cnt(e.tag);
    @(negedge clk);
    chk({e.tag, ".ready_out"}, 32'(ready), 32'd1);
  endtask
  initial begin
    rstb = 1'b1; valid = 1'b0; n = '0; address = '0;
    e_hit = 0; e_miss = 0; e_rd = 0; e_wr = 0;
    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.hit", 32'(hit), 32'd0);
    chk("rst.evict", 32'(evict), 32'd0);
    chk_cnt("rst");
    rstb = 1'b0;
    issue("t1_miss", RD, 32'h0000_1000, 2, 0, 0, 0, 0, 0, 0);
    issue("t1_hit", RD, 32'h0000_1000, 2, 1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++)
      issue($sformatf("t2_fill%0d", k), RD, 32'(k) * 32'h4000, 2, 0, k, 0, 0, 0, 0);
    issue("t2_evict", RD, 32'h0002_0000, 2, 0, 0, 1, 32'h0, 1'b0, 0);
    issue("t3_wr_hit", WR, 32'h0000_1000, 2, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k < 8; k++)
      issue($sformatf("t3_fill%0d", k), RD, 32'h1000 + 32'(k) * 32'h4000, 2, 0, k, 0, 0, 0, 0);
    issue("t3_evict_dirty", RD, 32'h0002_1000, 2, 0, 0, 1, 32'h0000_1000, 1'b1, 0);
    issue("prn", PRN, 32'h0000_1000, 2, 0, -1, 0, 0, 0, 0);
    issue("code5", 4'd5, 32'h0000_1000, 2, 0, -1, 0, 0, 0, 0);
    issue("t4_clr", CLR, 32'h0, 256, -1, -1, -1, 0, 0, 0);
    issue("t4_after_clr", RD, 32'h0000_1000, 2, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++)
      issue($sformatf("t5_miss%0d", k), RD, 32'h400 + 32'(k) * 32'h4000, 2, 0,
            k < 8 ? k : (k == 8 ? 0 : -1), k < 8 ? 0 : (k == 8 ? 1 : 2), 32'h400, 1'b0, 0);
    issue("t5_inv", INV, 32'h0004_c400, 2, 0, -1, 1, 32'h0004_c400, 1'b0, 0);
    issue("t5_after_inv", RD, 32'h0004_c400, 2, 0, -1, 0, 0, 0, 0);
    @(negedge clk);
    valid = 1'b1; n = RD; address = 32'h0004_c400;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; rstb = 1'b1;
    @(negedge clk);
    e_hit = 0; e_miss = 0; e_rd = 0; e_wr = 0;
    chk("t6_lookup.done", 32'(done), 32'd0);
    chk("t6_lookup.ready", 32'(ready), 32'd1);
    chk_cnt("t6_lookup");
    rstb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t6_lookup.quiet%0d", i), 32'(done), 32'd0);
    end
    issue("t6_relookup", RD, 32'h0004_c400, 2, 0, 0, 0, 0, 0, 0);
    issue("t6_high_set", RD, 32'h0000_3c00, 2, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    valid = 1'b1; n = CLR; address = '0;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (50) @(negedge clk);
    chk("t6_clr.busy", 32'(ready), 32'd0);
    rstb = 1'b1;
    @(negedge clk);
    e_hit = 0; e_miss = 0; e_rd = 0; e_wr = 0;
    chk("t6_clr.done", 32'(done), 32'd0);
    chk("t6_clr.ready", 32'(ready), 32'd1);
    chk_cnt("t6_clr");
    rstb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t6_clr.quiet%0d", i), 32'(done), 32'd0);
    end
    issue("t6_high_set_again", RD, 32'h0000_3c00, 2, 0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
